// File: rtl/quidditch_pkg.sv
// quidditch_pkg: shared frame geometry, team position limits, sequencer states and clamped step helper
package quidditch_pkg;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int H_VIS_MIN = 144;
  localparam int H_VIS_MAX = 783;
  localparam int V_VIS_MIN = 35;
  localparam int V_VIS_MAX = 514;
  localparam logic [10:0] POS_MIN = 11'd49;
  localparam logic [10:0] POS_MAX = 11'd500;
  localparam logic [10:0] POS_INIT = 11'd274;
  localparam logic [10:0] STEP = 11'd4;
  typedef enum logic [1:0] {SERVE, PLAY, PAUSED} seq_state_t;
  function automatic logic [9:0] step_pos(input logic [9:0] pos, input logic up, input logic dn);
    logic [10:0] p;
    p = {1'b0, pos};
    p = (up && !dn) ? ((p - STEP < POS_MIN) ? POS_MIN : p - STEP) :
        (dn && !up) ? ((p + STEP > POS_MAX) ? POS_MAX : p + STEP) : p;
    return p[9:0];
  endfunction
endpackage

// File: rtl/quidditch_frame_sequencer_if.sv
// quidditch_frame_sequencer_if: board request inputs and frame/position outputs of the sequencer
interface quidditch_frame_sequencer_if;
  logic t1_up, t1_dn, t2_up, t2_dn, pause_req, recenter_req;
  logic pix_en, frame_start, paused;
  logic [9:0] current_pixel, current_line, team1_ver_pos, team2_ver_pos;
  modport master(output t1_up, t1_dn, t2_up, t2_dn, pause_req, recenter_req,
                 input pix_en, frame_start, paused, current_pixel, current_line, team1_ver_pos, team2_ver_pos);
  modport slave(input t1_up, t1_dn, t2_up, t2_dn, pause_req, recenter_req,
                output pix_en, frame_start, paused, current_pixel, current_line, team1_ver_pos, team2_ver_pos);
endinterface

// File: rtl/team_pos_unit.sv
// team_pos_unit: latches one team's up/down requests and applies a clamped move at frame end
module team_pos_unit
  import quidditch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       dn,
  input  logic       fe,
  input  logic       apply,
  input  logic       recenter,
  output logic [9:0] pos
);
  logic up_p, dn_p;
  // pending flags clear at frame end; a request seen on that same edge is consumed by it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      up_p <= 1'b0;
      dn_p <= 1'b0;
      pos  <= POS_INIT[9:0];
    end else begin
      up_p <= !fe && (up_p || up);
      dn_p <= !fe && (dn_p || dn);
      if (fe && recenter) pos <= POS_INIT[9:0];
      else if (fe && apply) pos <= step_pos(pos, up_p || up, dn_p || dn);
    end
endmodule

// File: rtl/quidditch_frame_sequencer.sv
// quidditch_frame_sequencer: pixel/line counters, serve/play/pause FSM and per-frame team moves; QFS_PIXEL_DIV_EN halves the pixel rate
module quidditch_frame_sequencer
  import quidditch_pkg::*;
#(
  parameter int H_CNT = quidditch_pkg::H_TOTAL,
  parameter int V_CNT = quidditch_pkg::V_TOTAL
) (
  input logic clk,
  input logic reset,
  quidditch_frame_sequencer_if.slave bus
);
  localparam logic [9:0] H_LAST = 10'(H_CNT - 1);
  localparam logic [9:0] V_LAST = 10'(V_CNT - 1);
  seq_state_t state_q, state_d;
  logic pause_p, rc_p, pause_eff, rc_eff, fe, apply, recenter;
`ifdef QFS_PIXEL_DIV_EN
  // divide-by-two pixel tick; first tick lands on the second clk after reset
  always_ff @(posedge clk or posedge reset)
    if (reset) bus.pix_en <= 1'b0;
    else bus.pix_en <= !bus.pix_en;
`else
  assign bus.pix_en = 1'b1;
`endif
  assign fe = bus.pix_en && bus.current_pixel == H_LAST && bus.current_line == V_LAST;
  assign pause_eff = pause_p || bus.pause_req;
  assign rc_eff = rc_p || bus.recenter_req;
  assign bus.paused = state_q == PAUSED;
  // raster counters; frame_start marks only the first clk of the (0,0) tick period
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.current_pixel <= '0;
      bus.current_line  <= '0;
      bus.frame_start   <= 1'b0;
    end else begin
      bus.frame_start <= fe;
      if (bus.pix_en) begin
        bus.current_pixel <= bus.current_pixel == H_LAST ? '0 : bus.current_pixel + 10'd1;
        if (bus.current_pixel == H_LAST)
          bus.current_line <= bus.current_line == V_LAST ? '0 : bus.current_line + 10'd1;
      end
    end
  // state register and frame-scoped pause/recenter request latches
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= SERVE;
      pause_p <= 1'b0;
      rc_p    <= 1'b0;
    end else begin
      state_q <= state_d;
      pause_p <= !fe && pause_eff;
      rc_p    <= !fe && rc_eff;
    end
  // frame-end transitions; recenter outranks pause, moves only land while playing
  always_comb begin
    state_d  = state_q;
    apply    = state_q == PLAY;
    recenter = rc_eff && state_q != SERVE;
    if (fe)
      state_d = state_q == SERVE ? PLAY :
                rc_eff ? SERVE :
                pause_eff ? (state_q == PLAY ? PAUSED : PLAY) : state_q;
  end
  team_pos_unit u_team1 (
    .clk(clk), .reset(reset), .up(bus.t1_up), .dn(bus.t1_dn), .fe(fe),
    .apply(apply), .recenter(recenter), .pos(bus.team1_ver_pos)
  );
  team_pos_unit u_team2 (
    .clk(clk), .reset(reset), .up(bus.t2_up), .dn(bus.t2_dn), .fe(fe),
    .apply(apply), .recenter(recenter), .pos(bus.team2_ver_pos)
  );
endmodule

// File: tb/tb_quidditch_frame_sequencer.sv
// tb_quidditch_frame_sequencer: directed checks of counters, moves, clamping, pause/recenter and reset on a shrunken frame
module tb_quidditch_frame_sequencer;
  localparam int H = 20;
  localparam int V = 12;
`ifdef QFS_PIXEL_DIV_EN
  localparam int DIV = 2;
  localparam logic PIX_EN_RST = 1'b0;
`else
  localparam int DIV = 1;
  localparam logic PIX_EN_RST = 1'b1;
`endif
  localparam int FR = H * V * DIV;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  quidditch_frame_sequencer_if bus();
  quidditch_frame_sequencer #(.H_CNT(H), .V_CNT(V)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_t1(input logic up, input logic dn);
    bus.t1_up = up;
    bus.t1_dn = dn;
    @(negedge clk);
    bus.t1_up = 1'b0;
    bus.t1_dn = 1'b0;
  endtask

  task automatic to_frame_start();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.frame_start && k < 2 * FR);
    tests++;
    if (bus.frame_start !== 1'b1) begin
      fails++;
      $display("FAIL frame_start_timeout: got %b after %0d clks, need 1", bus.frame_start, k);
    end
  endtask

  task automatic chk_pos(input string name, input logic [9:0] p1, input logic [9:0] p2);
    tests++;
    if (bus.team1_ver_pos !== p1 || bus.team2_ver_pos !== p2) begin
      fails++;
      $display("FAIL %s: team1=%0d team2=%0d, need %0d %0d", name, bus.team1_ver_pos, bus.team2_ver_pos, p1, p2);
    end
  endtask

  task automatic test_reset();
    {bus.t1_up, bus.t1_dn, bus.t2_up, bus.t2_dn, bus.pause_req, bus.recenter_req} = '0;
    reset = 1'b1;
    step(3);
    tests++;
    if (bus.current_pixel !== 10'd0 || bus.current_line !== 10'd0) begin
      fails++;
      $display("FAIL reset_counters: got %0d,%0d need 0,0", bus.current_pixel, bus.current_line);
    end
    chk_pos("reset_pos", 10'd274, 10'd274);
    tests++;
    if (bus.frame_start !== 1'b0 || bus.paused !== 1'b0 || bus.pix_en !== PIX_EN_RST) begin
      fails++;
      $display("FAIL reset_flags: fs=%b paused=%b pix_en=%b need 0 0 %b", bus.frame_start, bus.paused, bus.pix_en, PIX_EN_RST);
    end
    reset = 1'b0;
  endtask

  task automatic test_counters();
    int n;
`ifdef QFS_PIXEL_DIV_EN
    for (int i = 0; i < 4; i++) begin
      step(1);
      tests++;
      if (bus.pix_en !== ((i % 2) == 0)) begin
        fails++;
        $display("FAIL pix_en_toggle: clk %0d got %b", i + 1, bus.pix_en);
      end
    end
    step(DIV * (H - 1) - 4);
`else
    step(DIV * (H - 1));
`endif
    tests++;
    if (bus.current_pixel !== 10'(H - 1) || bus.current_line !== 10'd0) begin
      fails++;
      $display("FAIL pixel_last: got %0d,%0d need %0d,0", bus.current_pixel, bus.current_line, H - 1);
    end
    step(DIV);
    tests++;
    if (bus.current_pixel !== 10'd0 || bus.current_line !== 10'd1) begin
      fails++;
      $display("FAIL pixel_wrap: got %0d,%0d need 0,1", bus.current_pixel, bus.current_line);
    end
    pulse_t1(1'b1, 1'b0);
    n = DIV * H + 1;
    while (!bus.frame_start && n < 2 * FR) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== FR || bus.current_pixel !== 10'd0 || bus.current_line !== 10'd0) begin
      fails++;
      $display("FAIL frame_period: got %0d clks at %0d,%0d need %0d at 0,0", n, bus.current_pixel, bus.current_line, FR);
    end
    chk_pos("serve_discard", 10'd274, 10'd274);
    step(1);
    tests++;
    if (bus.frame_start !== 1'b0) begin
      fails++;
      $display("FAIL frame_start_width: got %b on 2nd clk need 0", bus.frame_start);
    end
  endtask

  task automatic test_move();
    step(DIV * H * 5);
    pulse_t1(1'b1, 1'b0);
    step(10);
    chk_pos("move_waits_fe", 10'd274, 10'd274);
    to_frame_start();
    chk_pos("move_up", 10'd270, 10'd274);
  endtask

  task automatic test_both();
    step(20);
    pulse_t1(1'b1, 1'b0);
    step(30);
    pulse_t1(1'b0, 1'b1);
    to_frame_start();
    chk_pos("up_and_down", 10'd270, 10'd274);
  endtask

  task automatic test_fe_edge();
    int k;
    k = 0;
    while (!(bus.current_pixel == 10'(H - 1) && bus.current_line == 10'(V - 1) && bus.pix_en) && k < 2 * FR) begin
      @(negedge clk);
      k++;
    end
    pulse_t1(1'b1, 1'b0);
    tests++;
    if (bus.frame_start !== 1'b1) begin
      fails++;
      $display("FAIL fe_locate: frame_start=%b need 1", bus.frame_start);
    end
    chk_pos("fe_clk_request", 10'd266, 10'd274);
    to_frame_start();
    chk_pos("fe_no_carry", 10'd266, 10'd274);
  endtask

  task automatic test_saturate();
    logic [9:0] exp2;
    exp2 = 10'd274;
    bus.t2_dn = 1'b1;
    for (int f = 0; f < 70; f++) begin
      to_frame_start();
      exp2 = (exp2 + 10'd4 > 10'd500) ? 10'd500 : exp2 + 10'd4;
      tests++;
      if (bus.team2_ver_pos !== exp2) begin
        fails++;
        $display("FAIL saturate_f%0d: team2=%0d need %0d", f, bus.team2_ver_pos, exp2);
      end
    end
    bus.t2_dn = 1'b0;
    chk_pos("saturate_end", 10'd266, 10'd500);
  endtask

  task automatic test_pause();
    step(5);
    bus.pause_req = 1'b1;
    step(1);
    bus.pause_req = 1'b0;
    to_frame_start();
    tests++;
    if (bus.paused !== 1'b1) begin
      fails++;
      $display("FAIL pause_enter: paused=%b need 1", bus.paused);
    end
    for (int f = 0; f < 3; f++) begin
      step(7);
      pulse_t1(1'b0, 1'b1);
      bus.t2_up = 1'b1;
      step(1);
      bus.t2_up = 1'b0;
      to_frame_start();
      chk_pos("paused_frozen", 10'd266, 10'd500);
      tests++;
      if (bus.paused !== 1'b1) begin
        fails++;
        $display("FAIL paused_hold_f%0d: paused=%b need 1", f, bus.paused);
      end
    end
    bus.pause_req = 1'b1;
    step(1);
    bus.pause_req = 1'b0;
    to_frame_start();
    tests++;
    if (bus.paused !== 1'b0) begin
      fails++;
      $display("FAIL pause_resume: paused=%b need 0", bus.paused);
    end
    pulse_t1(1'b0, 1'b1);
    to_frame_start();
    chk_pos("resume_move", 10'd270, 10'd500);
    bus.pause_req = 1'b1;
    bus.recenter_req = 1'b1;
    bus.t2_up = 1'b1;
    step(1);
    {bus.pause_req, bus.recenter_req, bus.t2_up} = '0;
    to_frame_start();
    chk_pos("recenter", 10'd274, 10'd274);
    tests++;
    if (bus.paused !== 1'b0) begin
      fails++;
      $display("FAIL recenter_state: paused=%b need 0", bus.paused);
    end
    pulse_t1(1'b1, 1'b0);
    to_frame_start();
    chk_pos("serve_after_recenter", 10'd274, 10'd274);
  endtask

  task automatic test_reset_mid();
    pulse_t1(1'b0, 1'b1);
    to_frame_start();
    chk_pos("pre_reset_move", 10'd278, 10'd274);
    step(13);
    bus.t1_up = 1'b1;
    #2 reset = 1'b1;
    #1;
    bus.t1_up = 1'b0;
    tests++;
    if (bus.current_pixel !== 10'd0 || bus.current_line !== 10'd0 || bus.frame_start !== 1'b0 || bus.paused !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: %0d,%0d fs=%b paused=%b need 0,0 0 0", bus.current_pixel, bus.current_line, bus.frame_start, bus.paused);
    end
    chk_pos("async_reset_pos", 10'd274, 10'd274);
    @(negedge clk);
    reset = 1'b0;
    to_frame_start();
    chk_pos("reset_serve", 10'd274, 10'd274);
    pulse_t1(1'b0, 1'b1);
    to_frame_start();
    chk_pos("reset_then_play", 10'd278, 10'd274);
  endtask

  initial begin
    test_reset();
    test_counters();
    test_move();
    test_both();
    test_fe_edge();
    test_saturate();
    test_pause();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/quidditch_frame_sequencer.md
# quidditch_frame_sequencer

Frame-level sequencer feeding the pixel colour stage. Generates the 800×525 pixel/line counters consumed as `current_pixel`/`current_line`. Owns both team vertical positions: latches button move requests and applies them once per frame at the frame boundary, with clamping and a small play/pause/serve state machine. Sits between the board inputs and the VGA colour/sync logic.

## Interface
- `H_TOTAL`, 800: pixels per line, counter range 0..H_TOTAL-1
- `V_TOTAL`, 525: lines per frame, counter range 0..V_TOTAL-1
- `POS_MIN`, 49: smallest legal team position (top of visible area plus radius)
- `POS_MAX`, 500: largest legal team position
- `POS_INIT`, 274: reset/serve position for both teams
- `STEP`, 4: lines moved per accepted request

- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `t1_up`, `t1_dn`, `t2_up`, `t2_dn` in 1 each: move-request levels, already synchronised
- `pause_req` in 1: level; any high sample toggles play/pause at next frame end
- `recenter_req` in 1: level; any high sample recentres at next frame end
- `pix_en` out 1: pixel tick qualifier
- `current_pixel` out 10: horizontal counter
- `current_line` out 10: vertical counter
- `team1_ver_pos`, `team2_ver_pos` out 10 each: team positions
- `frame_start` out 1: one-clk pulse at first clk of counters (0,0)
- `paused` out 1: high in PAUSED

## Operation
- Reset values: counters 0, both positions POS_INIT, state SERVE, all pending flags 0, `frame_start` 0, `paused` 0, `pix_en` 0 (macro on) / 1 (macro off).
- Counters advance only on tick clks (`pix_en`=1). Pixel wraps 799→0 and then increments line; line wraps 524→0.
- Frame end (FE) = tick clk with pixel=799, line=524. All position/state updates happen on the FE edge.
- Pending flags (t1u, t1d, t2u, t2d, pause, recenter): set on any clk the input is high. FE uses pending OR current input, then clears all flags. An input high during FE is consumed by that FE.
- States:
  - SERVE: moves discarded. At FE, go to PLAY.
  - PLAY: at FE apply moves. Then recenter has priority over pause: recenter → positions POS_INIT, SERVE; else pause → PAUSED.
  - PAUSED: moves discarded, positions frozen. At FE, recenter → POS_INIT, SERVE; else pause → PLAY.
- Move per team (PLAY only): up and down both pending → no move; up → pos-STEP, floor POS_MIN; down → pos+STEP, ceiling POS_MAX. Compute in 11 bits so no underflow or wrap. Position outside the limits is unreachable.
- Teams are independent and update in the same FE.

## Timing
- Counter outputs are registered. Positions change on the same edge as the counters move to (0,0), so values are stable for the whole frame.
- Request latency: from any request to the visible position is at most one frame. An early-frame request waits until FE.
- `frame_start` is registered and high only in the first clk of the (0,0) tick period, even when the divider holds the counters for 2 clks.
- Reset mid-frame: immediate asynchronous return to reset values; pending requests are lost.

## Configuration
- `QFS_PIXEL_DIV_EN` defined: `pix_en` is a toggle flop (reset 0, so the first tick is the 2nd clk). Counters advance every other clk, for a 50 MHz clk driving 25 MHz pixels.
- Undefined: `pix_en` is tied to 1 and counters advance every clk.

## Structure
- Package `quidditch_pkg`: H_TOTAL/V_TOTAL/POS_* defaults, visible-window bounds (pixel 144..783, line 35..514), and the `seq_state_t` enum {SERVE, PLAY, PAUSED}.
- Sub-module `team_pos_unit`, instantiated twice. It holds the up/down pending flags and does the clamped update. Inputs: FE strobe, apply enable, recenter.

## Test plan
- Reset, macro off: after 800×525 clks `frame_start` pulses again, pixel/line sequence is 799→0 and line 524→0; positions stay 274 through the first FE (SERVE).
- In PLAY, pulse `t1_up` for 1 clk at line 100: `team1_ver_pos` stays 274 until FE, then becomes 270; team2 stays 274.
- Hold `t2_dn` continuously for 70 frames from 274: position steps +4 per frame and saturates at 500, never exceeds it.
- `t1_up` and `t1_dn` both pulsed in the same frame: no change. `t1_up` high only during the FE clk: it moves at that FE.
- `pause_req` pulse → PAUSED at FE. Moves are ignored for 3 frames. A second pause resumes, and `recenter_req` together with `pause_req` in PLAY gives both teams 274 and SERVE.
- With `QFS_PIXEL_DIV_EN`: `pix_en` alternates 0,1 from reset, one frame takes 840000 clks, and `frame_start` lasts exactly 1 clk.
